// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state encoding, step count and op-control codes for the divider
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DIV_ZERO = 2'b01,
    ON       = 2'b10,
    END      = 2'b11
  } div_state_t;

  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned WORD_W    = 32;

  localparam logic [3:0] AND_CONTROL  = 4'b0000;
  localparam logic [3:0] OR_CONTROL   = 4'b0001;
  localparam logic [3:0] ADD_CONTROL  = 4'b0010;
  localparam logic [3:0] XOR_CONTROL  = 4'b0011;
  localparam logic [3:0] NOR_CONTROL  = 4'b0100;
  localparam logic [3:0] SUB_CONTROL  = 4'b0110;
  localparam logic [3:0] SLT_CONTROL  = 4'b0111;
  localparam logic [3:0] SLTU_CONTROL = 4'b1000;
  localparam logic [3:0] MULT_CONTROL = 4'b1001;
  localparam logic [3:0] MULTU_CONTROL = 4'b1010;
  localparam logic [3:0] DIV_CONTROL  = 4'b1011;
  localparam logic [3:0] DIVU_CONTROL = 4'b1100;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [WORD_W-1:0] abs32(input logic [WORD_W-1:0] x);
    return x[WORD_W-1] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-compare-subtract iteration on {remainder, quotient}
module div_step
  import div_seq_pkg::*;
(
  input  logic [64:0]       work,
  input  logic [WORD_W-1:0] divisor,
  output logic [64:0]       work_next
);

  logic [32:0] partial;
  logic [32:0] diff;
  logic        take;

  // work[64] set would mean the shifted remainder already exceeds any 32-bit divisor.
  always_comb begin
    partial   = {work[63:32], work[31]};
    diff      = partial - {1'b0, divisor};
    take      = work[64] | (partial >= {1'b0, divisor});
    work_next = take ? {diff, work[30:0], 1'b1} : {partial, work[30:0], 1'b0};
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - 32-bit sequential signed/unsigned divider with annul and divide-by-zero handling
module div_seq
  import div_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              annul,
  output logic              busy,
  output logic              done,
  output logic [63:0]       result
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS);

  div_state_t        state, next_state;
  logic [5:0]        count;
  logic [64:0]       work, work_next;
  logic [WORD_W-1:0] divisor_mag;
  logic [WORD_W-1:0] dividend;
  logic              neg_q, neg_r;
  logic [WORD_W-1:0] quo_fix, rem_fix;
  logic              accept;

  assign accept = (state == IDLE) && start && !annul;

  div_step u_step (
    .work      (work),
    .divisor   (divisor_mag),
    .work_next (work_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start && !annul) next_state = (b == '0) ? DIV_ZERO : ON;
      DIV_ZERO: next_state = annul ? IDLE : END;
      ON: begin
        if (annul)                   next_state = IDLE;
        else if (count == LAST_STEP) next_state = END;
      end
      END:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ON) || (state == DIV_ZERO);
    done = (state == END) && !annul;
  end

  always_comb begin
    quo_fix = neg_q ? (~work[31:0] + 32'd1) : work[31:0];
    rem_fix = neg_r ? (~work[63:32] + 32'd1) : work[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      work        <= '0;
      divisor_mag <= '0;
      dividend    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dividend    <= a;
            divisor_mag <= signed_div ? abs32(b) : b;
            work        <= {33'b0, (signed_div ? abs32(a) : a)};
            neg_q       <= signed_div & (a[31] ^ b[31]);
            neg_r       <= signed_div & a[31];
            count       <= '0;
          end
        end
        DIV_ZERO: begin
          if (!annul) result <= {dividend, 32'hFFFF_FFFF};
        end
        ON: begin
          if (annul) begin
            count <= '0;
          end else if (count == LAST_STEP) begin
            result <= {rem_fix, quo_fix};
          end else begin
            work  <= work_next;
            count <= count + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq: vector table, corner sequences, random vs model
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Truncating division on sign- or zero-extended 64-bit values.
  function automatic logic [63:0] model(input logic sg, input logic [31:0] x, input logic [31:0] y);
    longint lx, ly, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    lx = sg ? {{32{x[31]}}, x} : {32'd0, x};
    ly = sg ? {{32{y[31]}}, y} : {32'd0, y};
    q  = lx / ly;
    r  = lx % ly;
    return {r[31:0], q[31:0]};
  endfunction

  // Call at a negedge while the DUT is idle; returns just after the accepting edge.
  task automatic issue(input logic sg, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; signed_div = sg; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; signed_div = 1'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input bit noise, output int lat, output int busy_cnt,
                           output int done_cnt, output logic [63:0] res);
    lat = -1; busy_cnt = 0; done_cnt = 0; res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin lat = k; res = result; end
      end
      if (noise && busy) begin
        start = 1'($urandom); signed_div = 1'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      if (lat > 0 && k >= lat + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic sg, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input bit noise);
    int lat, bc, dc;
    logic [63:0] res;
    @(negedge clk);
    issue(sg, x, y);
    wait_done(noise, lat, bc, dc, res);
    check({name, " result"}, res, exp);
    check({name, " latency"}, 64'(lat), (y == 0) ? 64'd2 : 64'd34);
    check({name, " busy cycles"}, 64'(bc), (y == 0) ? 64'd1 : 64'd33);
    check({name, " done pulses"}, 64'(dc), 64'd1);
    check({name, " result hold"}, result, exp);
  endtask

  initial begin
    int dc;
    logic [63:0] prev;
    logic [31:0] ra, rb;
    logic rs;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
    tbl[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    tbl[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF, 32'h0000_1234};
    tbl[6]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9};
    tbl[7]  = '{1'b0, 32'd5,          32'd9,        32'd0,         32'd5};
    tbl[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,        32'd0};
    tbl[9]  = '{1'b1, 32'h8000_0000,  32'd1,        32'h8000_0000, 32'h0};
    tbl[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    tbl[11] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE};

    rst = 1'b1; start = 1'b1; annul = 1'b0; signed_div = 1'b0; a = 32'd9; b = 32'd3;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    start = 1'b0;
    rst = 1'b0;

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].sg, tbl[i].a, tbl[i].b, {tbl[i].r, tbl[i].q}, 1'b0);

    // start with annul in IDLE is dropped
    @(negedge clk);
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    check("idle annul busy", 64'(busy), 64'd0);

    // annul at step 10, then 50/5 right away
    prev = result;
    dc = 0;
    issue(1'b0, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) dc++;
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    if (done) dc++;
    check("annul busy", 64'(busy), 64'd0);
    check("annul result", result, prev);
    issue(1'b0, 32'd50, 32'd5);
    begin
      int lat, bc, dc2;
      logic [63:0] res;
      wait_done(1'b0, lat, bc, dc2, res);
      check("annul no done", 64'(dc), 64'd0);
      check("after annul result", res, {32'd0, 32'd10});
      check("after annul latency", 64'(lat), 64'd34);
      check("after annul done pulses", 64'(dc2), 64'd1);
    end

    // reset at step 20
    @(negedge clk);
    issue(1'b0, 32'd777, 32'd5);
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst result", result, 64'd0);
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("midrst no done", 64'(dc), 64'd0);

    // start pulses while busy are ignored
    run_op("noise 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    run_op("noise div0", 1'b1, 32'hDEAD_BEEF, 32'd0, {32'hDEAD_BEEF, 32'hFFFF_FFFF}, 1'b1);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
